packed_sat_addsub: RTL and testbench

- Parametrised packed-SIMD signed add/subtract unit with per-lane saturation; successor to the fixed 16-bit/4-lane saturating adder.
- Adds runtime add/sub and saturate/wrap modes, per-lane overflow flags, and a multi-cycle lane-serial datapath.
- Uses valid/ready handshakes on input and output. Sits in the EX stage as a multi-cycle functional unit that stalls the pipeline while busy.

---
 rtl/packed_sat_addsub.sv | 138 +++++++++++++
 tb/tb_packed_sat_addsub.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/packed_sat_addsub.sv
// Packed-SIMD signed add/subtract with per-lane saturation/wrap and overflow flags.
// Lanes are processed LANES_PER_CYC at a time; the result is presented only once complete.
module packed_sat_addsub #(
  parameter int DATA_W        = 16,
  parameter int LANE_W        = 4,
  parameter int LANES_PER_CYC = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W-1:0]            A,
  input  logic [DATA_W-1:0]            B,
  input  logic                         op_sub,
  input  logic                         sat_en,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            Result,
  output logic [DATA_W/LANE_W-1:0]     ovfl,
  output logic                         any_ovfl
);

  localparam int NUM_LANES = DATA_W / LANE_W;
  localparam int NUM_GRPS  = NUM_LANES / LANES_PER_CYC;
  localparam int GRP_BITS  = LANES_PER_CYC * LANE_W;
  localparam int GRP_W     = (NUM_GRPS > 1) ? $clog2(NUM_GRPS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  localparam logic [DATA_W-1:0]    GRP_MASK = DATA_W'({GRP_BITS{1'b1}});
  localparam logic [NUM_LANES-1:0] OVF_MASK = NUM_LANES'({LANES_PER_CYC{1'b1}});
  localparam logic [GRP_W-1:0]     LAST_GRP = GRP_W'(NUM_GRPS - 1);

  function automatic logic signed [LANE_W-1:0] saturate(
    input logic signed [LANE_W-1:0] s,
    input logic                     ovf,
    input logic                     neg,
    input logic                     sat
  );
    if (sat && ovf)
      return neg ? {1'b1, {(LANE_W-1){1'b0}}} : {1'b0, {(LANE_W-1){1'b1}}};
    return s;
  endfunction

  // Returns {overflow, lane result}; subtraction is a + ~b + 1 so the most-negative b wraps onto itself.
  function automatic logic [LANE_W:0] lane_op(
    input logic signed [LANE_W-1:0] a,
    input logic signed [LANE_W-1:0] b,
    input logic                     sub,
    input logic                     sat
  );
    logic signed [LANE_W-1:0] b_eff;
    logic signed [LANE_W-1:0] s;
    logic                     ovf;
    b_eff = sub ? ~b : b;
    s     = a + b_eff + LANE_W'(sub);
    ovf   = (sub ? (a[LANE_W-1] != b[LANE_W-1]) : (a[LANE_W-1] == b[LANE_W-1]))
            && (s[LANE_W-1] != a[LANE_W-1]);
    return {ovf, saturate(s, ovf, a[LANE_W-1], sat)};
  endfunction

  logic [1:0]            r_state;
  logic [GRP_W-1:0]      r_grp;
  logic [DATA_W-1:0]     r_a;
  logic [DATA_W-1:0]     r_b;
  logic                  r_sub;
  logic                  r_sat;
  logic [DATA_W-1:0]     r_result;
  logic [NUM_LANES-1:0]  r_ovfl;

  int                    w_shamt;
  int                    w_oshamt;
  logic [GRP_BITS-1:0]   w_grp_a;
  logic [GRP_BITS-1:0]   w_grp_b;
  logic [GRP_BITS-1:0]   w_grp_res;
  logic [LANES_PER_CYC-1:0] w_grp_ovf;

  assign w_shamt  = int'(r_grp) * GRP_BITS;
  assign w_oshamt = int'(r_grp) * LANES_PER_CYC;
  assign w_grp_a  = GRP_BITS'(r_a >> w_shamt);
  assign w_grp_b  = GRP_BITS'(r_b >> w_shamt);

  for (genvar g = 0; g < LANES_PER_CYC; g++) begin : g_lane
    logic [LANE_W:0] w_lane;
    assign w_lane = lane_op(w_grp_a[g*LANE_W +: LANE_W], w_grp_b[g*LANE_W +: LANE_W], r_sub, r_sat);
    assign w_grp_res[g*LANE_W +: LANE_W] = w_lane[LANE_W-1:0];
    assign w_grp_ovf[g] = w_lane[LANE_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_grp    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_sub    <= 1'b0;
      r_sat    <= 1'b0;
      r_result <= '0;
      r_ovfl   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= A;
            r_b     <= B;
            r_sub   <= op_sub;
            r_sat   <= sat_en;
            r_ovfl  <= '0;
            r_grp   <= '0;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          r_result <= (r_result & ~(GRP_MASK << w_shamt)) | (DATA_W'(w_grp_res) << w_shamt);
          r_ovfl   <= (r_ovfl & ~(OVF_MASK << w_oshamt)) | (NUM_LANES'(w_grp_ovf) << w_oshamt);
          if (r_grp == LAST_GRP) begin
            r_state <= S_HOLD;
          end else begin
            r_grp <= r_grp + 1'b1;
          end
        end
        S_HOLD: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_HOLD);
  assign Result    = r_result;
  assign ovfl      = r_ovfl;
  assign any_ovfl  = |r_ovfl;

endmodule

// File: tb/tb_packed_sat_addsub.sv
// Scoreboard bench for packed_sat_addsub: one lane-serial instance and one fully parallel instance.
module tb_packed_sat_addsub;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, op_sub = 1'b0, sat_en = 1'b0, out_ready = 1'b0;
  logic [15:0] A = '0, B = '0;
  logic        in_ready, out_valid, any_ovfl;
  logic [15:0] Result;
  logic [3:0]  ovfl;

  logic        in_valid4 = 1'b0, op_sub4 = 1'b0, sat_en4 = 1'b0, out_ready4 = 1'b0;
  logic [15:0] A4 = '0, B4 = '0;
  logic        in_ready4, out_valid4, any_ovfl4;
  logic [15:0] Result4;
  logic [3:0]  ovfl4;

  int n_chk = 0;
  int n_err = 0;
  logic [19:0] exp_q[$];
  logic [19:0] exp_q4[$];

  always #5 clk = ~clk;

  packed_sat_addsub #(.DATA_W(16), .LANE_W(4), .LANES_PER_CYC(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .op_sub(op_sub), .sat_en(sat_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .Result(Result), .ovfl(ovfl), .any_ovfl(any_ovfl)
  );

  packed_sat_addsub #(.DATA_W(16), .LANE_W(4), .LANES_PER_CYC(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .A(A4), .B(B4), .op_sub(op_sub4), .sat_en(sat_en4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .Result(Result4), .ovfl(ovfl4), .any_ovfl(any_ovfl4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Integer reference: exact lane sum/difference, then clamp or wrap to 4 bits.
  function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic sub, input logic sat);
    logic [15:0] r;
    logic [3:0]  f;
    logic [3:0]  la, lb;
    int x, y, s, v;
    r = '0;
    f = '0;
    for (int i = 0; i < 4; i++) begin
      la = 4'(a >> (4*i));
      lb = 4'(b >> (4*i));
      x  = int'($signed(la));
      y  = int'($signed(lb));
      s  = sub ? x - y : x + y;
      v  = s;
      if (sat && s > 7)  v = 7;
      if (sat && s < -8) v = -8;
      r  = r | (16'(v & 15) << (4*i));
      if (s > 7 || s < -8) f = f | (4'b0001 << i);
    end
    return {f, r};
  endfunction

  task automatic collect(input string tag);
    logic [19:0] e;
    if (exp_q.size() == 0) begin
      check({tag, " scoreboard_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check({tag, " Result"}, 32'(Result), 32'(e[15:0]));
      check({tag, " ovfl"}, 32'(ovfl), 32'(e[19:16]));
      check({tag, " any_ovfl"}, 32'(any_ovfl), 32'(|e[19:16]));
    end
  endtask

  task automatic start_op(input logic [15:0] a, input logic [15:0] b,
                          input logic sub, input logic sat, input string tag);
    check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    exp_q.push_back(model(a, b, sub, sat));
    A = a; B = b; op_sub = sub; sat_en = sat; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int cyc;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, " latency"}, 32'(cyc), 32'd4);
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic sub, input logic sat, input string tag);
    start_op(a, b, sub, sat, tag);
    wait_out(tag);
    collect(tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [19:0] e4;
    int cyc;

    #12;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset Result", 32'(Result), 32'd0);
    check("reset ovfl", 32'(ovfl), 32'd0);
    check("reset any_ovfl", 32'(any_ovfl), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(16'h7777, 16'h1111, 1'b0, 1'b1, "add_pos_sat");
    run_op(16'h8888, 16'h8888, 1'b0, 1'b1, "add_neg_sat");
    run_op(16'h8888, 16'h8888, 1'b0, 1'b0, "add_neg_wrap");
    run_op(16'h1234, 16'h1111, 1'b0, 1'b1, "add_noovf");
    run_op(16'h8070, 16'h1F01, 1'b1, 1'b1, "sub_sat");
    run_op(16'h8070, 16'h1F01, 1'b1, 1'b0, "sub_wrap");
    run_op(16'h0000, 16'h8888, 1'b1, 1'b1, "sub_minB_sat");
    run_op(16'h0000, 16'h8888, 1'b1, 1'b0, "sub_minB_wrap");
    for (int k = 0; k < 6; k++)
      run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), "random");

    // Backpressure: result must hold and new operands must be refused.
    start_op(16'h1234, 16'h1111, 1'b0, 1'b1, "bp");
    wait_out("bp");
    A = 16'hFFFF; B = 16'hFFFF; op_sub = 1'b1; sat_en = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("bp out_valid", 32'(out_valid), 32'd1);
      check("bp in_ready", 32'(in_ready), 32'd0);
      check("bp Result", 32'(Result), 32'h2345);
      check("bp ovfl", 32'(ovfl), 32'd0);
    end
    in_valid = 1'b0;
    collect("bp");
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp release out_valid", 32'(out_valid), 32'd0);
    check("bp release in_ready", 32'(in_ready), 32'd1);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check("bp no_extra_op", 32'(out_valid), 32'd0);
    end

    // Reset during CALC at group 2: the partial operation is dropped entirely.
    check("rst_mid in_ready", 32'(in_ready), 32'd1);
    A = 16'h7777; B = 16'h1111; op_sub = 1'b0; sat_en = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid out_valid", 32'(out_valid), 32'd0);
    check("rst_mid Result", 32'(Result), 32'd0);
    check("rst_mid ovfl", 32'(ovfl), 32'd0);
    check("rst_mid in_ready", 32'(in_ready), 32'd1);
    #5;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(16'h7777, 16'h1111, 1'b0, 1'b1, "after_rst");

    // Fully parallel instance: one-cycle latency.
    check("p4 in_ready", 32'(in_ready4), 32'd1);
    exp_q4.push_back(model(16'h7777, 16'h1111, 1'b0, 1'b1));
    A4 = 16'h7777; B4 = 16'h1111; op_sub4 = 1'b0; sat_en4 = 1'b1; in_valid4 = 1'b1;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    cyc = 0;
    while (!out_valid4 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("p4 latency", 32'(cyc), 32'd1);
    if (exp_q4.size() == 0) begin
      check("p4 scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e4 = exp_q4.pop_front();
      check("p4 Result", 32'(Result4), 32'(e4[15:0]));
      check("p4 ovfl", 32'(ovfl4), 32'(e4[19:16]));
      check("p4 any_ovfl", 32'(any_ovfl4), 32'(|e4[19:16]));
    end
    out_ready4 = 1'b1;
    @(posedge clk); #1;
    out_ready4 = 1'b0;
    check("p4 back_to_idle", 32'(in_ready4), 32'd1);

    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
